ram_rd_control_stream: RTL and testbench
========================================

Name: ram_rd_control_stream

Overview:
Read-side counterpart of the RAM write controllers. It reads a fixed, parameterised sequence of entries from the 16x32 local RAM (half-word lanes selected per entry) and emits them as one bus packet using the sop/eop/vld beat format. A 2-entry internal buffer absorbs the 1-cycle RAM read latency, so downstream out_rdy backpressure never drops data. It sits between the local data/weight RAM and the result bus toward the host/DMA side.

Parameters:
RD_LEN, 5, number of RAM reads (and output beats) per packet; legal range 1..8.
ADDR_SEQ, {4'd8,4'd6,4'd4,4'd2,4'd0}, 4*RD_LEN bits; entry k read address is in bits [4k+3:4k], with entry 0 in the LSBs.
STRB_SEQ, {2'b01,2'b11,2'b11,2'b11,2'b11}, 2*RD_LEN bits; entry k lane mask is in bits [2k+1:2k]; bit0 selects data[15:0], bit1 selects data[31:16].

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle request to send one packet; honoured only when busy=0
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, the cycle after the eop beat is accepted
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  4  RAM read address; 0 when ram_rd_en=0
ram_rd_data  in  32  RAM read data; valid exactly 1 cycle after ram_rd_en
out_vld  out  1  output beat valid
out_rdy  in  1  downstream ready
out_sop  out  1  first beat of packet; qualified by out_vld
out_eop  out  1  last beat of packet; qualified by out_vld
out_data  out  32  beat data, with unselected lanes forced to 0

Behaviour:
- Reset: all registered state clears at the clk edge where rst_n=0 (synchronous reset). All outputs read 0, the FSM is IDLE, the buffer is empty and any in-flight read is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start. The cycle start is sampled: rd_idx<=0, out_idx<=0, busy<=1.
  - ISSUE -> DRAIN after the read with rd_idx=RD_LEN-1 is issued.
  - DRAIN -> IDLE on the edge where the eop beat handshakes (out_vld & out_rdy & out_eop). At that edge, done<=1 for one cycle and busy<=0.
- start is ignored when busy=1 or done=1. There is no queueing.
- Read issue: ram_rd_en = (state==ISSUE) & ((fifo_cnt + inflight - pop) < 2).
  - pop = out_vld & out_rdy.
  - inflight is a 1-bit register equal to ram_rd_en delayed by 1 cycle.
  - ram_rd_addr = ADDR_SEQ[4*rd_idx +: 4] when ram_rd_en=1, else 0. rd_idx increments on each issue.
  - ram_rd_en and ram_rd_addr are combinational from registered state plus out_rdy.
- Capture: when inflight=1, push {ram_rd_data masked by STRB_SEQ[2*cap_idx +: 2]} into the buffer. A masked lane is 16'h0000. cap_idx increments on each push.
- Output: out_vld = buffer non-empty; out_data = buffer head.
  - out_sop = out_vld & (out_idx==0); out_eop = out_vld & (out_idx==RD_LEN-1).
  - out_idx increments on each pop.
  - Head data, sop and eop stay stable while out_vld=1 and out_rdy=0.
- Latency with out_rdy=1: start at edge T gives ram_rd_en in cycle T+1 and first out_vld in cycle T+3. Beats then follow back-to-back at 1 per cycle, RD_LEN beats total.
- Buffer boundaries: a simultaneous push and pop on a full buffer is legal, and the count is unchanged. A push to a full buffer without a pop cannot occur; the credit rule guarantees this, and the bench asserts it. A pop when empty is impossible because out_vld=0.
- Widths: fifo_cnt is 2 bits (0..2). rd_idx, cap_idx and out_idx are 3 bits; $clog2(8) covers RD_LEN<=8.
- With RD_LEN=1, sop and eop are on the same beat.
- Reset mid-packet: the packet is abandoned, and no eop or done is produced. The next start produces a complete packet starting at entry 0.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - RAM geometry constants (RAM_AW=4, RAM_DW=32, LANE_W=16);
  - lane-mask localparams (STRB_LO=2'b01, STRB_HI=2'b10, STRB_ALL=2'b11);
  - the default address/strobe tables, shared with the write controllers.
- One sub-module, ram_rd_skid_fifo: a 2-entry synchronous FIFO (push, pop, din, dout, cnt, empty, full).

Test Plan:
1. Default params, RAM[a]=32'hA000_0000|a, out_rdy=1, one start -> 5 back-to-back beats A0000000, A0000002, A0000004, A0000006, 00000008. sop on beat1, eop on beat5, done the cycle after beat5, busy low thereafter.
2. Same setup, out_rdy=0 for 6 cycles from the first out_vld -> at most 2 reads issued before the stall (never 3). Beat1 is held stable. After release, all 5 beats arrive in order with no loss or duplication.
3. start pulsed again 2 cycles after the first start -> ignored. Exactly 5 beats and 1 done.
4. RD_LEN=1, ADDR_SEQ=4'd15, STRB_SEQ=2'b10, RAM[15]=32'h1234_5678 -> a single beat 32'h1234_0000 with sop=eop=1.
5. rst_n low for 1 cycle after beat2 is accepted -> the next cycle has out_vld=0, busy=0 and no done. A new start then yields the full 5-beat packet beginning with sop at address 0.
6. out_rdy pattern 1,0,1,0,… -> 5 beats in order, out_data stable across each stall cycle, done one cycle after eop acceptance.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ram_ctrl_pkg : shared RAM geometry, lane masks and default entry tables
// Rev 1.0
// ============================================================================
package ram_ctrl_pkg;

   localparam int RAM_AW     = 4;
   localparam int RAM_DW     = 32;
   localparam int LANE_W     = 16;
   localparam int MAX_RD_LEN = 8;
   localparam int IDX_W      = $clog2(MAX_RD_LEN);

   localparam logic [1:0] STRB_LO  = 2'b01;
   localparam logic [1:0] STRB_HI  = 2'b10;
   localparam logic [1:0] STRB_ALL = 2'b11;

   localparam int                DEF_RD_LEN   = 5;
   localparam logic [4*5-1:0]    DEF_ADDR_SEQ = {4'd8, 4'd6, 4'd4, 4'd2, 4'd0};
   localparam logic [2*5-1:0]    DEF_STRB_SEQ = {STRB_LO, STRB_ALL, STRB_ALL, STRB_ALL, STRB_ALL};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Unselected half-word lanes read back as zero.
   function automatic logic [RAM_DW-1:0] apply_strb(input logic [RAM_DW-1:0] d,
                                                    input logic [1:0]        s);
      return {s[1] ? d[RAM_DW-1:LANE_W] : {LANE_W{1'b0}},
              s[0] ? d[LANE_W-1:0]      : {LANE_W{1'b0}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rd_control_stream_if.sv
`default_nettype none
// ============================================================================
// ram_rd_control_stream_if : control, RAM read port and output beat stream
// Rev 1.0
// ============================================================================
interface ram_rd_control_stream_if;
   import ram_ctrl_pkg::*;

   logic              start;
   logic              busy;
   logic              done;
   logic              ram_rd_en;
   logic [RAM_AW-1:0] ram_rd_addr;
   logic [RAM_DW-1:0] ram_rd_data;
   logic              out_vld;
   logic              out_rdy;
   logic              out_sop;
   logic              out_eop;
   logic [RAM_DW-1:0] out_data;

   modport master (
      input  start, ram_rd_data, out_rdy,
      output busy, done, ram_rd_en, ram_rd_addr, out_vld, out_sop, out_eop, out_data
   );

   modport slave (
      output start, ram_rd_data, out_rdy,
      input  busy, done, ram_rd_en, ram_rd_addr, out_vld, out_sop, out_eop, out_data
   );
endinterface
`default_nettype wire

// File: rtl/ram_rd_control_stream_skid_fifo.sv
`default_nettype none
// ============================================================================
// ram_rd_skid_fifo : 2-entry synchronous FIFO absorbing the RAM read latency
// Rev 1.0
// ============================================================================
module ram_rd_skid_fifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic [1:0]   cnt_o,
   output logic         empty_o,
   output logic         full_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   cnt_q;
   logic         do_push;
   logic         do_pop;

   // A push into a full buffer is only taken when a pop frees a slot that cycle.
   assign do_pop  = pop_i & (cnt_q != 2'd0);
   assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign cnt_o   = cnt_q;
   assign empty_o = (cnt_q == 2'd0);
   assign full_o  = (cnt_q == 2'd2);
endmodule
`default_nettype wire

// File: rtl/ram_rd_control_stream.sv
`default_nettype none
// ============================================================================
// ram_rd_control_stream : reads a fixed RAM entry sequence, emits one packet
// Rev 1.0
// ============================================================================
module ram_rd_control_stream
   import ram_ctrl_pkg::*;
#(
   parameter int                  RD_LEN   = DEF_RD_LEN,
   parameter logic [4*RD_LEN-1:0] ADDR_SEQ = DEF_ADDR_SEQ,
   parameter logic [2*RD_LEN-1:0] STRB_SEQ = DEF_STRB_SEQ
) (
   input  logic                      clk,
   input  logic                      rst_n,
   ram_rd_control_stream_if.master   bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RD_LEN - 1);

   rd_state_e          state_q;
   logic [IDX_W-1:0]   rd_idx_q;
   logic [IDX_W-1:0]   cap_idx_q;
   logic [IDX_W-1:0]   out_idx_q;
   logic               inflight_q;
   logic               busy_q;
   logic               done_q;

   logic               rd_en;
   logic               push;
   logic               pop;
   logic [2:0]         occ;
   logic [RAM_DW-1:0]  push_data;
   logic [RAM_DW-1:0]  fifo_dout;
   logic [1:0]         fifo_cnt;
   logic               fifo_empty;
   logic               fifo_full;
   logic               fifo_vld;

   logic [RAM_AW-1:0]  addr_tab [MAX_RD_LEN];
   logic [1:0]         strb_tab [MAX_RD_LEN];

   // Unused table slots are padded so every index value is well defined.
   for (genvar k = 0; k < MAX_RD_LEN; k++) begin : g_tab
      if (k < RD_LEN) begin : g_used
         assign addr_tab[k] = ADDR_SEQ[4*k +: 4];
         assign strb_tab[k] = STRB_SEQ[2*k +: 2];
      end else begin : g_pad
         assign addr_tab[k] = '0;
         assign strb_tab[k] = '0;
      end
   end

   assign fifo_vld  = ~fifo_empty;
   assign pop       = fifo_vld & bus.out_rdy;
   assign push      = inflight_q;
   assign push_data = apply_strb(bus.ram_rd_data, strb_tab[cap_idx_q]);

   // Credit: buffered + in-flight beats, less the one leaving, must stay below 2.
   assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en = (state_q == ST_ISSUE) & (occ < 3'd2);

   ram_rd_skid_fifo #(
      .W (RAM_DW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (push_data),
      .dout_o  (fifo_dout),
      .cnt_o   (fifo_cnt),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rd_idx_q   <= '0;
         cap_idx_q  <= '0;
         out_idx_q  <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= rd_en;
         if (rd_en) rd_idx_q  <= rd_idx_q + 1'b1;
         if (push)  cap_idx_q <= cap_idx_q + 1'b1;
         if (pop)   out_idx_q <= out_idx_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (bus.start && !busy_q && !done_q) begin
                  state_q   <= ST_ISSUE;
                  rd_idx_q  <= '0;
                  cap_idx_q <= '0;
                  out_idx_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (rd_en && rd_idx_q == LAST_IDX) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && out_idx_q == LAST_IDX) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.ram_rd_en   = rd_en;
   assign bus.ram_rd_addr = rd_en ? addr_tab[rd_idx_q] : '0;
   assign bus.out_vld     = fifo_vld;
   assign bus.out_data    = fifo_dout;
   assign bus.out_sop     = fifo_vld & (out_idx_q == '0);
   assign bus.out_eop     = fifo_vld & (out_idx_q == LAST_IDX);
endmodule
`default_nettype wire

// File: tb/tb_ram_rd_control_stream.sv
`default_nettype none
// ============================================================================
// tb_ram_rd_control_stream : directed self-checking bench, default and 1-entry
// Rev 1.0
// ============================================================================
module tb_ram_rd_control_stream;
   logic clk = 1'b0;
   logic rst_n0 = 1'b0;
   logic rst_n1 = 1'b0;
   always #5 clk = ~clk;

   ram_rd_control_stream_if if0 ();
   ram_rd_control_stream_if if1 ();

   ram_rd_control_stream u_dut0 (.clk(clk), .rst_n(rst_n0), .bus(if0.master));

   ram_rd_control_stream #(
      .RD_LEN   (1),
      .ADDR_SEQ (4'd15),
      .STRB_SEQ (2'b10)
   ) u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(if1.master));

   function automatic logic [31:0] ram_val(input logic [3:0] a);
      return (a == 4'd15) ? 32'h1234_5678 : (32'hA000_0000 | {28'h0, a});
   endfunction

   always @(posedge clk) begin
      if (if0.ram_rd_en) if0.ram_rd_data <= ram_val(if0.ram_rd_addr);
      if (if1.ram_rd_en) if1.ram_rd_data <= ram_val(if1.ram_rd_addr);
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_addr(input int k);
      case (k)
         0: return 4'd0;
         1: return 4'd2;
         2: return 4'd4;
         3: return 4'd6;
         4: return 4'd8;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] exp_beat(input int k);
      case (k)
         0: return 32'hA000_0000;
         1: return 32'hA000_0002;
         2: return 32'hA000_0004;
         3: return 32'hA000_0006;
         4: return 32'h0000_0008;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Buffer overflow observer: a push into a full buffer with no pop.
   bit ovf_seen = 1'b0;
   always @(posedge clk) begin
      if (u_dut0.push && u_dut0.fifo_full && !u_dut0.pop) ovf_seen = 1'b1;
   end

   logic [31:0] bt_data[$];
   bit          bt_sop[$];
   bit          bt_eop[$];
   int done_cnt, done_cyc, eop_cyc, first_vld, max_out, n_reads;

   task automatic start0();
      @(negedge clk);
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
   endtask

   // mode 0: always ready; 1: stall stall_n cycles from first vld; 2: ready 1,0,1,0...
   task automatic run_beats(input int mode, input int stall_n, input int restart_at);
      int cyc, reads, pops, post;
      logic pv, prdy, ps, pe, rdy;
      logic [31:0] pd;
      cyc = 0; reads = 0; pops = 0; post = 0;
      pv = 1'b0; prdy = 1'b1; ps = 1'b0; pe = 1'b0; pd = '0;
      bt_data.delete(); bt_sop.delete(); bt_eop.delete();
      done_cnt = 0; done_cyc = -1; eop_cyc = -1; first_vld = -1; max_out = 0;
      while (cyc < 200 && post < 3) begin
         if (if0.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc > done_cyc) begin
            post++;
            check_eq("busy_after_done", 32'(if0.busy), 32'd0);
            check_eq("vld_after_done", 32'(if0.out_vld), 32'd0);
         end
         if (pv && !prdy) begin
            check_eq("stall_vld", 32'(if0.out_vld), 32'd1);
            check_eq("stall_data", if0.out_data, pd);
            check_eq("stall_sop", 32'(if0.out_sop), 32'(ps));
            check_eq("stall_eop", 32'(if0.out_eop), 32'(pe));
         end
         if (if0.out_vld && first_vld < 0) first_vld = cyc;
         case (mode)
            1:       rdy = (first_vld < 0) ? 1'b1 : ((cyc - first_vld) >= stall_n);
            2:       rdy = (first_vld < 0) ? 1'b1 : (((cyc - first_vld) % 2) == 0);
            default: rdy = 1'b1;
         endcase
         if0.out_rdy = rdy;
         if0.start   = (cyc == restart_at);
         #1;
         if (if0.ram_rd_en) begin
            check_eq($sformatf("rd_addr%0d", reads), 32'(if0.ram_rd_addr), 32'(exp_addr(reads)));
            reads++;
         end
         if (if0.out_vld && rdy) begin
            bt_data.push_back(if0.out_data);
            bt_sop.push_back(if0.out_sop);
            bt_eop.push_back(if0.out_eop);
            if (if0.out_eop) eop_cyc = cyc;
            pops++;
         end
         if (reads - pops > max_out) max_out = reads - pops;
         pv = if0.out_vld; prdy = rdy; pd = if0.out_data; ps = if0.out_sop; pe = if0.out_eop;
         @(negedge clk);
         cyc++;
      end
      if0.start   = 1'b0;
      if0.out_rdy = 1'b1;
      n_reads = reads;
      if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic verify_packet(input string tag);
      check_eq({tag, "_nbeats"}, 32'(bt_data.size()), 32'd5);
      check_eq({tag, "_nreads"}, 32'(n_reads), 32'd5);
      for (int k = 0; k < bt_data.size() && k < 5; k++) begin
         check_eq($sformatf("%s_data%0d", tag, k), bt_data[k], exp_beat(k));
         check_eq($sformatf("%s_sop%0d", tag, k), 32'(bt_sop[k]), 32'(k == 0));
         check_eq($sformatf("%s_eop%0d", tag, k), 32'(bt_eop[k]), 32'(k == 4));
      end
      check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'(eop_cyc + 1));
      check_eq({tag, "_max_out_le2"}, 32'(max_out <= 2), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops;
      if0.start = 1'b0; if0.out_rdy = 1'b1;
      if1.start = 1'b0; if1.out_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(if0.busy), 32'd0);
      check_eq("rst_done", 32'(if0.done), 32'd0);
      check_eq("rst_vld", 32'(if0.out_vld), 32'd0);
      check_eq("rst_rd_en", 32'(if0.ram_rd_en), 32'd0);
      check_eq("rst_addr", 32'(if0.ram_rd_addr), 32'd0);
      check_eq("rst_sop_eop", {30'd0, if0.out_sop, if0.out_eop}, 32'd0);
      rst_n0 = 1'b1;
      rst_n1 = 1'b1;
      @(negedge clk);

      // 1: basic packet and latency
      start0();
      check_eq("t1_busy", 32'(if0.busy), 32'd1);
      check_eq("t1_rd_en", 32'(if0.ram_rd_en), 32'd1);
      run_beats(0, 0, -1);
      verify_packet("t1");
      check_eq("t1_first_vld", 32'(first_vld), 32'd2);

      // 2: stall 6 cycles from first vld
      start0();
      run_beats(1, 6, -1);
      verify_packet("t2");

      // 3: second start while busy is ignored
      start0();
      run_beats(0, 0, 1);
      verify_packet("t3");

      // 5: reset after beat 2 accepted, then a fresh packet
      start0();
      if0.out_rdy = 1'b1;
      pops = 0;
      for (int c = 0; c < 50 && pops < 2; c++) begin
         if (if0.out_vld) pops++;
         @(negedge clk);
      end
      check_eq("t5_two_beats", 32'(pops), 32'd2);
      rst_n0 = 1'b0;
      @(negedge clk);
      rst_n0 = 1'b1;
      check_eq("t5_vld", 32'(if0.out_vld), 32'd0);
      check_eq("t5_busy", 32'(if0.busy), 32'd0);
      check_eq("t5_done", 32'(if0.done), 32'd0);
      check_eq("t5_rd_en", 32'(if0.ram_rd_en), 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("t5_no_done", {30'd0, if0.done, if0.out_vld}, 32'd0);
      end
      start0();
      run_beats(0, 0, -1);
      verify_packet("t5");

      // 6: alternating ready
      start0();
      run_beats(2, 0, -1);
      verify_packet("t6");

      check_eq("no_overflow", 32'(ovf_seen), 32'd0);

      // 4: single-entry instance, upper lane only
      @(negedge clk);
      if1.start = 1'b1;
      @(negedge clk);
      if1.start = 1'b0;
      for (int c = 0; c < 10 && !if1.out_vld; c++) @(negedge clk);
      check_eq("t4_vld", 32'(if1.out_vld), 32'd1);
      check_eq("t4_data", if1.out_data, 32'h1234_0000);
      check_eq("t4_sop", 32'(if1.out_sop), 32'd1);
      check_eq("t4_eop", 32'(if1.out_eop), 32'd1);
      @(negedge clk);
      check_eq("t4_done", 32'(if1.done), 32'd1);
      check_eq("t4_vld_after", 32'(if1.out_vld), 32'd0);
      @(negedge clk);
      check_eq("t4_done_pulse", 32'(if1.done), 32'd0);
      check_eq("t4_busy", 32'(if1.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
